// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : lsu_pkg                                                    |
// | Description : Shared constants, FSM state type and request legality      |
// |               helpers for the load/store unit.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package lsu_pkg;

  // RV32I funct3 encodings for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // data_mem write_en codes
  localparam logic [1:0] WE_WORD = 2'b00;
  localparam logic [1:0] WE_HALF = 2'b01;
  localparam logic [1:0] WE_BYTE = 2'b10;
  localparam logic [1:0] WE_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // Legal funct3 for the direction, and natural alignment for the size.
  function automatic logic lsu_legal(input logic we, input logic [2:0] f3,
                                     input logic [1:0] addr_lo);
    logic ok;
    if (we) begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
    end
    if ((f3[1:0] == 2'b01) && addr_lo[0]) ok = 1'b0;
    if ((f3[1:0] == 2'b10) && (addr_lo != 2'b00)) ok = 1'b0;
    return ok;
  endfunction

  // Store size code; only called for legal stores (funct3 000/001/010).
  function automatic logic [1:0] lsu_we_code(input logic [2:0] f3);
    logic [1:0] code;
    case (f3[1:0])
      2'b00:   code = WE_BYTE;
      2'b01:   code = WE_HALF;
      default: code = WE_WORD;
    endcase
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : load_store_unit_if                                         |
// | Description : Request/response handshake from execute/writeback plus the |
// |               data_mem port of the load/store unit.                      |
// |   req_*  : request (valid/ready, we, funct3, addr, wdata)                |
// |   rsp_*  : single-cycle response (valid, rdata, err)                     |
// |   mem_*  : data_mem write_en/addr/data_in out, data_out in               |
// |   slave  : view used by the load/store unit                              |
// |   master : view used by the environment (requester + memory)            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [1:0]        mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_write_en, mem_addr, mem_data_in
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_write_en, mem_addr, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit_load_extend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_extend                                                |
// | Description : Sign/zero extension of raw data_mem output per load funct3.|
// |   i_funct3 : load funct3 (LB/LH/LW/LBU/LHU)                              |
// |   i_raw    : 32-bit word from data_mem, addressed byte in [7:0]          |
// |   o_data   : extended load result                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_extend
  import lsu_pkg::*;
(
  input  wire logic [2:0]  i_funct3,
  input  wire logic [31:0] i_raw,
  output logic      [31:0] o_data
);
  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
      F3_BU:   o_data = {24'h0, i_raw[7:0]};
      F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_HU:   o_data = {16'h0, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : load_store_unit                                            |
// | Description : Data-memory initiator. Accepts one load/store at a time,   |
// |               checks funct3/alignment, drives data_mem, waits out the    |
// |               read latency and returns a one-cycle response.             |
// |   clk, rst   : clock, asynchronous active-high reset                     |
// |   bus        : load_store_unit_if.slave (req_*, rsp_*, mem_*)            |
// |   ADDR_W     : address width                                             |
// |   MEM_RD_LAT : data_mem read latency in edges (1..4)                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  load_store_unit_if.slave bus
);
  localparam logic [1:0] c_lat_init = 2'(MEM_RD_LAT - 1);

  lsu_state_t        r_state;
  logic [1:0]        r_cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [1:0]        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_legal;
  logic [31:0]       w_ext;

  assign w_legal = lsu_legal(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  load_extend u_load_extend (
    .i_funct3 (r_f3),
    .i_raw    (bus.mem_data_out),
    .o_data   (w_ext)
  );

  // All outputs are registered; mem_write_en can only leave WE_NONE for the
  // single ISSUE cycle of a legal store, and reset forces it back at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_we        <= 1'b0;
      r_f3        <= 3'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_we    <= WE_NONE;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            r_we        <= bus.req_we;
            r_f3        <= bus.req_funct3;
            r_req_ready <= 1'b0;
            if (!w_legal) begin
              // Rejected without touching memory
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_state    <= ST_ISSUE;
              r_mem_addr <= bus.req_addr;
              if (bus.req_we) begin
                r_mem_we    <= lsu_we_code(bus.req_funct3);
                r_mem_wdata <= bus.req_wdata;
              end
            end
          end
        end
        ST_ISSUE: begin
          r_mem_we <= WE_NONE;
          if (r_we) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
          end else begin
            // data_mem samples the address at this edge
            r_state <= ST_WAIT;
            r_cnt   <= c_lat_init;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_ext;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 32'h0;
          r_rsp_err   <= 1'b0;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_mem_we    <= WE_NONE;
        end
      endcase
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.mem_write_en = r_mem_we;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_data_in  = r_mem_wdata;

endmodule
`default_nettype wire
